right_shift_seq: RTL and testbench
==================================

RIGHT_SHIFT_SEQ -- requirements
Module: right_shift_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter SHW, default 5, giving the shift-amount width; SHW = clog2(WIDTH).
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 start  input  1  Request to begin a shift; accepted only when ready=1.
REQ-006 d  input  WIDTH  Operand, captured on the accept edge.
REQ-007 shamt  input  SHW  Shift amount 0..WIDTH-1, captured on the accept edge.
REQ-008 arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured on the accept edge.
REQ-009 ready  output  1  High in IDLE only.
REQ-010 busy  output  1  High in SHIFT only.
REQ-011 done  output  1  One-cycle pulse, high in DONE only.
REQ-012 q  output  WIDTH  Registered result.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE, with ready, busy and done each a decode of the state register.
REQ-014 IDLE with start=1 SHALL load the working register with d, the counter with shamt, and the fill bit with arith AND d[WIDTH-1], then enter SHIFT.
REQ-015 IDLE with start=0 SHALL remain in IDLE with all registers unchanged.
REQ-016 In SHIFT with counter != 0, each edge SHALL shift the working register right by 1, insert the fill bit at the MSB, and decrement the counter.
REQ-017 In SHIFT with counter == 0, the edge SHALL copy the working register to q and enter DONE.
REQ-018 DONE SHALL last exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-019 The latency SHALL be shamt+1 edges from the accept edge to the edge that raises done, including shamt=0 (2-cycle accept-to-done, done visible one cycle after the accept edge +1).
REQ-020 q SHALL change only on the SHIFT-to-DONE edge and hold its value at all other times, including across IDLE.
REQ-021 start SHALL be ignored while in SHIFT or DONE, with no queuing of the request.
REQ-022 Changes on d, shamt or arith after the accept edge SHALL NOT affect the in-flight result.
REQ-023 The counter SHALL be SHW bits wide and SHALL never wrap, because decrement occurs only when counter != 0.
REQ-024 A start in the cycle immediately after done SHALL be accepted, because the state is IDLE, giving back-to-back throughput of one operation per shamt+3 cycles.

Reset
REQ-025 reset=1 SHALL force state=IDLE, q=0, working register=0, counter=0 and fill=0 on the next edge.
REQ-026 Reset SHALL override start and any in-progress operation; an aborted operation SHALL produce no done pulse and SHALL leave q=0.
REQ-027 In the cycle after reset deasserts, outputs SHALL be ready=1, busy=0, done=0.

Structure
REQ-028 A shared package SHALL hold the state enum type (IDLE, SHIFT, DONE) and the default WIDTH constant of 32.
REQ-029 The block SHALL be a single module with no sub-modules; the shifter datapath and the FSM are small enough to live together.

Verification
REQ-030 d=0x80000000, shamt=4, arith=1 -> q=0xF8000000, done high 5 edges after the accept edge, busy high for 5 cycles.
REQ-031 d=0x80000000, shamt=4, arith=0 -> q=0x08000000, same timing as REQ-030.
REQ-032 d=0x12345678, shamt=0, arith=1 -> q=0x12345678, done on the 1st edge after the accept edge; d=0xFFFFFFFF, shamt=31, arith=0 -> q=0x00000001 after 32 edges.
REQ-033 Accept d=0xF0000000, shamt=8, arith=0; on the 3rd busy cycle drive start=1, d=0, shamt=1 -> the second request is ignored, q=0x00F00000, exactly one done pulse.
REQ-034 Accept shamt=10; assert reset for 1 cycle on the 4th busy cycle -> ready=1, q=0 and no done pulse; a following request d=0x00000100, shamt=8 -> q=0x00000001.
REQ-035 Back-to-back: start asserted in the cycle after done, with d=0x00000010, shamt=4 -> accepted, q=0x00000001, done 5 edges later.

Source files
------------

// File: rtl/right_shift_seq_pkg.sv
// Shared types and defaults for the sequential right shifter.
package right_shift_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/right_shift_seq.sv
// Sequential right shifter: one bit position per clock, logical or arithmetic fill.
module right_shift_seq
    import right_shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   count;
    logic             fill;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            work  <= '0;
            count <= '0;
            fill  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= d;
                        count <= shamt;
                        fill  <= arith & d[WIDTH-1];
                    end
                end
                SHIFT: begin
                    // The counter only decrements while non-zero, so it can never wrap.
                    if (count != '0) begin
                        work  <= {fill, work[WIDTH-1:1]};
                        count <= count - SHW'(1);
                    end else begin
                        q <= work;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)         state_next = SHIFT;
            SHIFT:   if (count == '0)   state_next = DONE;
            DONE:                       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_right_shift_seq.sv
// Self-checking bench: directed corner cases plus random operations against a shift model.
module tb_right_shift_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   shamt;
    logic             arith;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;

    int total = 0;
    int bad   = 0;

    right_shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .d     (d),
        .shamt (shamt),
        .arith (arith),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] dv, input int sh, input logic ar);
        if (ar) return WIDTH'($signed(dv) >>> sh);
        return dv >> sh;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge after DONE.
    // A non-zero inject_at drives a competing request on that busy cycle.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] dv, input int sh,
                          input logic ar, input int inject_at);
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] q_before;
        int edges;
        int busy_cnt;
        bit q_moved;
        exp_q    = model(dv, sh, ar);
        q_before = q;
        start = 1'b1;
        d     = dv;
        shamt = SHW'(sh);
        arith = ar;
        @(negedge clk);
        start = 1'b0;
        d     = $urandom;
        shamt = SHW'($urandom);
        arith = 1'($urandom);
        edges    = 0;
        busy_cnt = 0;
        q_moved  = 1'b0;
        while (!done && edges <= WIDTH + 4) begin
            if (busy) busy_cnt++;
            if (q !== q_before) q_moved = 1'b1;
            start = 1'b0;
            if (inject_at != 0 && busy_cnt == inject_at) begin
                start = 1'b1;
                d     = '0;
                shamt = SHW'(1);
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check({tag, " done"}, WIDTH'(done), WIDTH'(1));
        check({tag, " latency"}, WIDTH'(edges), WIDTH'(sh + 1));
        check({tag, " busy_cycles"}, WIDTH'(busy_cnt), WIDTH'(sh + 1));
        check({tag, " q_held"}, WIDTH'(q_moved), WIDTH'(0));
        check({tag, " q"}, q, exp_q);
        @(negedge clk);
        check({tag, " ready_after"}, WIDTH'(ready), WIDTH'(1));
        check({tag, " done_pulse"}, WIDTH'(done), WIDTH'(0));
        check({tag, " q_hold_idle"}, q, exp_q);
    endtask

    initial begin
        logic [WIDTH-1:0] q_keep;
        bit saw_done;
        reset = 1'b1;
        start = 1'b0;
        d     = '0;
        shamt = '0;
        arith = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset ready", WIDTH'(ready), WIDTH'(1));
        check("reset busy", WIDTH'(busy), WIDTH'(0));
        check("reset done", WIDTH'(done), WIDTH'(0));
        check("reset q", q, '0);

        run_op("arith_sign", 32'h8000_0000, 4, 1'b1, 0);
        run_op("logic_zero", 32'h8000_0000, 4, 1'b0, 0);
        run_op("shamt0", 32'h1234_5678, 0, 1'b1, 0);
        run_op("shamt31", 32'hFFFF_FFFF, 31, 1'b0, 0);

        // Idle with start low: nothing moves even when operands wiggle.
        q_keep = q;
        for (int i = 0; i < 3; i++) begin
            d     = $urandom;
            shamt = SHW'($urandom);
            arith = 1'($urandom);
            @(negedge clk);
        end
        check("idle ready", WIDTH'(ready), WIDTH'(1));
        check("idle q", q, q_keep);

        run_op("ignore_start", 32'hF000_0000, 8, 1'b0, 3);
        check("ignore_start no_requeue", WIDTH'(busy), WIDTH'(0));

        // Back-to-back: the second start lands in the idle cycle right after DONE.
        run_op("b2b_first", 32'hC000_0003, 2, 1'b1, 0);
        run_op("b2b_second", 32'h0000_0010, 4, 1'b0, 0);

        // Abort mid-shift with a one-cycle reset on the fourth busy cycle.
        start = 1'b1;
        d     = 32'hABCD_EF01;
        shamt = SHW'(10);
        arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if (done) saw_done = 1'b1;
        check("abort ready", WIDTH'(ready), WIDTH'(1));
        check("abort busy", WIDTH'(busy), WIDTH'(0));
        check("abort q", q, '0);
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", WIDTH'(saw_done), WIDTH'(0));
        check("abort q_stays", q, '0);
        run_op("after_abort", 32'h0000_0100, 8, 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            run_op($sformatf("rand%0d", n), $urandom, int'($urandom_range(0, WIDTH - 1)),
                   1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
